// File: rtl/excit_seq_ctrl_if.sv
// +----------------------------------------------------------------------+
// | excit_seq_ctrl_if: state/input bus to and excitations from the       |
// | combinational next-state block.                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface excit_seq_ctrl_if;
  logic [2:0] exc_q;
  logic       exc_x;
  logic [2:0] exc_d;
  logic [2:0] exc_t;

  modport master (output exc_q, output exc_x, input exc_d, input exc_t);
  modport slave  (input exc_q, input exc_x, output exc_d, output exc_t);
endinterface

`default_nettype wire

// File: rtl/excit_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | excit_seq_ctrl: steps a 3-bit state machine through an external     |
// | excitation block, capturing D or T excitations per run.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module excit_seq_ctrl #(
  parameter int CW         = 8,
  parameter int XW         = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode_t,
  input  logic [2:0]            seed,
  input  logic [CW-1:0]         n_steps,
  input  logic [XW-1:0]         x_pat,
  excit_seq_ctrl_if.master      exc,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         step_cnt,
  output logic                  loop_hit
);

  localparam int c_XIW = (XW > 1) ? $clog2(XW) : 1;
  localparam int c_SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_XIW-1:0] c_X_LAST = c_XIW'(XW - 1);
  localparam logic [c_SW-1:0]  c_S_LAST = c_SW'(SETTLE_CYC - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETTLE = 2'd1;
  localparam logic [1:0] c_ST_APPLY  = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [2:0]       r_q;
  logic [2:0]       r_seed;
  logic [CW-1:0]    r_n_steps;
  logic [CW-1:0]    r_step_cnt;
  logic             r_mode_t;
  logic [XW-1:0]    r_x_pat;
  logic [c_XIW-1:0] r_x_idx;
  logic [c_SW-1:0]  r_settle_cnt;
  logic             r_loop_hit;

  logic             w_settle_last;
  logic [CW-1:0]    w_step_inc;
  logic             w_last_step;
  logic             w_apply;
  logic [2:0]       w_q_nxt;

  assign w_settle_last = (r_settle_cnt == c_S_LAST);
  assign w_step_inc    = r_step_cnt + CW'(1);
  assign w_last_step   = (w_step_inc == r_n_steps);
  assign w_apply       = (r_state == c_ST_APPLY) && !abort;
  // Excitations are only looked at through this mux, gated by w_apply below.
  assign w_q_nxt       = r_mode_t ? (r_q ^ exc.exc_t) : exc.exc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_state_nxt = (n_steps == '0) ? c_ST_DONE : c_ST_SETTLE;
        end
      end
      c_ST_SETTLE: begin
        if (abort) begin
          w_state_nxt = c_ST_IDLE;
        end else if (w_settle_last) begin
          w_state_nxt = c_ST_APPLY;
        end
      end
      c_ST_APPLY: begin
        if (abort) begin
          w_state_nxt = c_ST_IDLE;
        end else if (w_last_step) begin
          w_state_nxt = c_ST_DONE;
        end else begin
          w_state_nxt = c_ST_SETTLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_ST_SETTLE: busy = 1'b1;
      c_ST_APPLY:  busy = 1'b1;
      c_ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q          <= '0;
      r_seed       <= '0;
      r_n_steps    <= '0;
      r_step_cnt   <= '0;
      r_mode_t     <= 1'b0;
      r_x_pat      <= '0;
      r_x_idx      <= '0;
      r_settle_cnt <= '0;
      r_loop_hit   <= 1'b0;
    end else if (r_state == c_ST_IDLE) begin
      if (start) begin
        r_seed       <= seed;
        r_n_steps    <= n_steps;
        r_mode_t     <= mode_t;
        r_x_pat      <= x_pat;
        r_q          <= seed;
        r_step_cnt   <= '0;
        r_loop_hit   <= 1'b0;
        r_settle_cnt <= '0;
        r_x_idx      <= '0;
      end
    end else if (r_state == c_ST_SETTLE) begin
      if (!abort && !w_settle_last) begin
        r_settle_cnt <= r_settle_cnt + c_SW'(1);
      end
    end else if (w_apply) begin
      r_q          <= w_q_nxt;
      r_step_cnt   <= w_step_inc;
      r_settle_cnt <= '0;
      // x index wraps at XW so no modulo hardware is needed.
      r_x_idx      <= (r_x_idx == c_X_LAST) ? '0 : r_x_idx + c_XIW'(1);
      if (w_q_nxt == r_seed) begin
        r_loop_hit <= 1'b1;
      end
    end
  end

  assign exc.exc_q = r_q;
  assign exc.exc_x = r_x_pat[r_x_idx];
  assign step_cnt  = r_step_cnt;
  assign loop_hit  = r_loop_hit;

endmodule

`default_nettype wire

// File: tb/tb_excit_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_excit_seq_ctrl: timeline model of runs, directed and random runs. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_excit_seq_ctrl;
  localparam int CW = 8;
  localparam int XW = 16;
  localparam int S  = 1;
  localparam int P  = S + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode_t = 1'b0;
  logic [2:0]    seed = '0;
  logic [CW-1:0] n_steps = '0;
  logic [XW-1:0] x_pat = '0;
  logic          busy, done, loop_hit;
  logic [CW-1:0] step_cnt;
  logic [2:0]    tab [0:15];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e0 = 0;
  int busy_cnt = 0, done_cnt = 0, done_cyc = -1;
  logic x_seen [0:15];

  excit_seq_ctrl_if bus ();

  excit_seq_ctrl #(.CW(CW), .XW(XW), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_t(mode_t),
    .seed(seed), .n_steps(n_steps), .x_pat(x_pat), .exc(bus.master),
    .busy(busy), .done(done), .step_cnt(step_cnt), .loop_hit(loop_hit)
  );

  // Stand-in excitation block: a lookup on {state, input bit}.
  assign bus.exc_d = tab[{bus.exc_q, bus.exc_x}];
  assign bus.exc_t = tab[{bus.exc_q, bus.exc_x}];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run model: a run is a timeline of cycles t = 0,1,... after the start edge.
  bit         m_valid = 0, m_active = 0;
  int         m_t = 0, m_hold = 0, m_n = 0;
  bit         m_mode = 0;
  logic [2:0] m_seed = '0;
  logic [XW-1:0] m_xpat = '0;
  logic [2:0] traj [0:256];

  function automatic int exp_k();
    return m_active ? (m_t / P) : m_hold;
  endfunction

  function automatic bit exp_loop(input int k);
    for (int j = 1; j <= k; j++) if (traj[j] == m_seed) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_active = 0; m_hold = 0; m_n = 0;
      m_seed = '0; m_xpat = '0; traj[0] = '0;
    end else if (m_valid) begin
      if (m_active) begin
        if (m_t == m_n * P) begin
          m_active = 0; m_hold = m_n;
        end else if (abort) begin
          m_active = 0; m_hold = m_t / P;
        end else begin
          m_t++;
        end
      end else if (start) begin
        logic [2:0] e;
        m_seed = seed; m_n = int'(n_steps); m_mode = mode_t; m_xpat = x_pat;
        traj[0] = seed;
        for (int k = 0; k < m_n; k++) begin
          e = tab[{traj[k], m_xpat[k % XW]}];
          traj[k+1] = m_mode ? (traj[k] ^ e) : e;
        end
        m_t = 0; m_active = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int k;
      k = exp_k();
      chk("exc_q", int'(bus.exc_q), int'(traj[k]));
      chk("exc_x", int'(bus.exc_x), int'(m_xpat[k % XW]));
      chk("step_cnt", int'(step_cnt), k);
      chk("loop_hit", int'(loop_hit), int'(exp_loop(k)));
      chk("busy", int'(busy), int'(m_active && (m_t < m_n * P)));
      chk("done", int'(done), int'(m_active && (m_t == m_n * P)));
      if (busy) begin
        busy_cnt++;
        x_seen[step_cnt[3:0]] = bus.exc_x;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tab(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: tab[i] = 3'(i / 2 + 1);
        1: tab[i] = 3'(i / 2);
        2: tab[i] = 3'b001;
        default: tab[i] = 3'($urandom_range(0, 7));
      endcase
    end
  endtask

  task automatic launch(input logic [2:0] s, input int n, input bit m, input logic [XW-1:0] xp);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    seed = s; n_steps = CW'(n); mode_t = m; x_pat = xp; start = 1'b1;
    tick();
    e0 = cyc;
    start = 1'b0;
    seed = 3'($urandom); n_steps = CW'($urandom); mode_t = 1'($urandom); x_pat = XW'($urandom);
  endtask

  task automatic wait_idle(input bit noise);
    int guard = 0;
    while ((busy || done) && guard < 2000) begin
      if (noise) begin
        abort = ($urandom_range(0, 24) == 0);
        start = ($urandom_range(0, 9) == 0);
      end
      tick();
      guard++;
    end
    abort = 1'b0; start = 1'b0;
    if (guard >= 2000) chk("idle_timeout", guard, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_tab(0);
    // Reset held with start high.
    rst_n = 1'b0; start = 1'b1; seed = 3'd5; n_steps = 8'd3;
    tick(); tick();
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q", int'(bus.exc_q), 0);
    start = 1'b0; rst_n = 1'b1;
    tick();

    // D mode counter: 3,4,5,6,7.
    set_tab(0);
    launch(3'd3, 4, 1'b0, XW'($urandom));
    wait_idle(0);
    chk("d_q", int'(bus.exc_q), 7);
    chk("d_step", int'(step_cnt), 4);
    chk("d_loop", int'(loop_hit), 0);
    chk("d_busy_cycles", busy_cnt, 8);
    chk("d_done_cnt", done_cnt, 1);
    chk("d_done_lat", done_cyc - e0, 8);

    // T mode toggling bit 0: 2 -> 3 -> 2.
    set_tab(2);
    launch(3'd2, 2, 1'b1, XW'($urandom));
    wait_idle(0);
    chk("t_q", int'(bus.exc_q), 2);
    chk("t_loop", int'(loop_hit), 1);
    chk("t_step", int'(step_cnt), 2);
    chk("t_done_cnt", done_cnt, 1);

    // Input sequencing with identity excitation.
    set_tab(1);
    launch(3'd6, 4, 1'b0, 16'h0005);
    wait_idle(0);
    chk("x_seq", int'({x_seen[3], x_seen[2], x_seen[1], x_seen[0]}), 4'b0101);
    chk("x_q", int'(bus.exc_q), 6);
    chk("x_loop", int'(loop_hit), 1);

    // Abort in the APPLY cycle of step 3, with an ignored start earlier.
    set_tab(0);
    launch(3'd0, 10, 1'b0, XW'($urandom));
    tick(); start = 1'b1; seed = 3'd7; n_steps = 8'd1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_q", int'(bus.exc_q), 2);
    chk("ab_step", int'(step_cnt), 2);
    chk("ab_busy", int'(busy), 0);
    tick(); tick();
    chk("ab_done_cnt", done_cnt, 0);

    // Zero-step run.
    set_tab(3);
    launch(3'd5, 0, 1'($urandom), XW'($urandom));
    wait_idle(0);
    chk("z_done_lat", done_cyc - e0, 0);
    chk("z_q", int'(bus.exc_q), 5);
    chk("z_step", int'(step_cnt), 0);
    chk("z_done_cnt", done_cnt, 1);

    // Reset mid-run.
    set_tab(0);
    launch(3'd1, 6, 1'b0, 16'hFFFF);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mr_q", int'(bus.exc_q), 0);
    chk("mr_x", int'(bus.exc_x), 0);
    chk("mr_step", int'(step_cnt), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_loop", int'(loop_hit), 0);
    rst_n = 1'b1;
    tick();

    // Random runs against the model.
    for (int r = 0; r < 60; r++) begin
      set_tab(3);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      launch(3'($urandom), $urandom_range(0, 20), 1'($urandom), XW'($urandom));
      wait_idle(1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/excit_seq_ctrl.md
Name: excit_seq_ctrl

Overview:
Controller that sequences the 3-bit state / 1-input excitation datapath (combinational next-state logic producing D-form and T-form excitations) as a real synchronous machine.
- Owns the 3-bit state register and presents the current state and input bit to the excitation block.
- Captures either the D or the T excitation, according to a per-run mode, for a requested number of steps.
- Reports step count, completion, and whether the machine revisited its seed state.
- Used as the stepping and verification harness for next-state logic exercises.

Parameters:
CW, 8, width of step counter and n_steps
XW, 16, length of input-bit pattern; exc_x cycles through x_pat bits
SETTLE_CYC, 1, cycles (>=1) exc_q/exc_x are held stable before capture

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous and active-low
start  in  1  begin a run; sampled only in IDLE
abort  in  1  cancel current run
mode_t  in  1  0 = capture exc_d (D flip-flops), 1 = q ^ exc_t (T flip-flops)
seed  in  3  initial state
n_steps  in  CW  number of state transitions to perform
x_pat  in  XW  input-bit pattern; step k uses x_pat[k mod XW]
exc_q  out  3  current state to excitation block (a,b,c)
exc_x  out  1  input bit to excitation block (d)
exc_d  in  3  D excitation from block
exc_t  in  3  T excitation from block
busy  out  1  run in progress
done  out  1  one-cycle pulse, run completed normally
step_cnt  out  CW  transitions performed in current/last run
loop_hit  out  1  sticky per run: state returned to seed after >=1 step

Behaviour:
- Reset (rst_n=0 at edge): FSM=IDLE; q=0; exc_q=0; exc_x=0; busy=0; done=0; step_cnt=0; loop_hit=0; latched config cleared.
- exc_q = q (registered). exc_x = latched x_pat[step_cnt mod XW] (registered or decoded from registers; no input-to-output combinational path).
- FSM states: IDLE, SETTLE, APPLY, DONE.
- IDLE, start=1:
  - Latch seed, n_steps, mode_t, x_pat.
  - q<=seed; step_cnt<=0; loop_hit<=0; settle counter<=0.
  - Next state is SETTLE, or DONE if n_steps==0.
  - busy=1 in SETTLE and APPLY only.
- SETTLE: hold exc_q/exc_x for SETTLE_CYC cycles, then go to APPLY.
- APPLY (1 cycle), at its closing edge:
  - q <= mode_t ? (q ^ exc_t) : exc_d.
  - step_cnt <= step_cnt+1.
  - If new q == latched seed, loop_hit<=1.
  - Next state is DONE if step_cnt+1 == n_steps, else SETTLE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. q, step_cnt and loop_hit hold until the next start.
- Latency: done is visible in the cycle after edge number n_steps*(SETTLE_CYC+1), counted from the start-sampling edge (edge 0). With n_steps=0, done is visible in the cycle right after edge 0.
- start while not in IDLE: ignored; config inputs are not re-sampled mid-run.
- abort=1 in SETTLE or APPLY:
  - Next state is IDLE; no done pulse.
  - q, step_cnt and loop_hit keep their values.
  - abort and APPLY in the same cycle: abort wins and q is not updated.
- abort in IDLE or DONE: ignored. start and abort both high in IDLE: start is taken.
- step_cnt never wraps within a run: max n_steps = 2^CW-1.
- rst_n low mid-run: full reset to the values above on that edge.
- exc_d and exc_t are sampled only at the APPLY edge; X on them at other times must not propagate.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with start=1 -> all outputs 0, FSM stays IDLE, no done pulse.
- D mode: bench models exc_d=(exc_q+1)%8; run with seed=3, n_steps=4, SETTLE_CYC=1 -> exc_q goes 3,4,5,6,7; done pulses in the cycle after edge 8; step_cnt=4; loop_hit=0; busy high for exactly 8 cycles.
- T mode: bench drives exc_t=3'b001; run with seed=2, n_steps=2 -> q goes 3 then 2; loop_hit=1; step_cnt=2; done once.
- Input sequencing: x_pat=16'h0005, n_steps=4, D mode with exc_d=exc_q -> exc_x over the four steps is 1,0,1,0; q stays equal to seed; loop_hit=1.
- Abort: D counter model, seed=0, n_steps=10; assert abort in the APPLY cycle of step 3 -> q=2, step_cnt=2, busy=0 next cycle, no done. A second start pulsed while busy earlier in the run is ignored.
- Edge cases:
  - n_steps=0, seed=5 -> done in the cycle after start, q=5, step_cnt=0.
  - rst_n=0 mid-run -> all outputs 0 on that edge.
